shift_issue_stage: RTL and testbench

Execute-side issue stage that directly feeds the 32-bit barrel shifter. It accepts decoded RV32I shift instructions with their operands over a valid/ready handshake and decodes SLL/SRL/SRA (register and immediate forms) into the shifter's operand, mode-select and shift-amount fields. It buffers them in a two-entry skid register so that neither handshake side has a combinational ready path. It also flags non-shift or malformed encodings.

---
 rtl/shift_issue_stage.sv | 202 ++++++++++++++++++++
 tb/tb_shift_issue_stage.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_issue_stage.sv
// shift_issue_stage - decodes RV32I shift instructions into barrel-shifter fields.
// Latency: one cycle (entry accepted at edge N drives dn_* from edge N onward).
// Backpressure: two-entry skid buffer, up_ready registered, no dn_ready->up_ready path.
//
// Purpose
//    Execute-side issue stage in front of the 32-bit barrel shifter. Accepts a
//    raw instruction word plus rs1/rs2 values, decodes SLL/SRL/SRA and their
//    immediate forms into shifter operand, mode select and shift amount, and
//    flags every other encoding as illegal (still forwarded, never dropped).
//
// Optional feature
//    SHIFT_ILLEGAL_CHK_EN : when defined, funct7 (instr[31:25]) is fully
//    checked; a non-canonical funct7 marks the entry illegal. When undefined,
//    only opcode, funct3 and instr[30] take part in decode.
//
// Ports
//    clk, rst        clock (rising edge) and asynchronous active-high reset
//    flush           synchronous flush, empties both buffer entries
//    up_valid/ready  upstream handshake (up_ready is a flop)
//    up_instr        raw 32-bit instruction word
//    up_rs1, up_rs2  value to shift, register-form shift amount source
//    dn_valid/ready  downstream handshake (dn_valid is a flop)
//    dn_in           shifter data input (rs1)
//    dn_sel          {1 = left / 0 = right, 1 = arithmetic / 0 = logical}
//    dn_B            shift amount
//    dn_rd           destination register, instr[11:7]
//    dn_illegal      entry is not a valid shift

module shift_issue_stage #(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               up_valid,
   output logic               up_ready,
   input  logic [31:0]        up_instr,
   input  logic [XLEN-1:0]    up_rs1,
   input  logic [XLEN-1:0]    up_rs2,
   output logic               dn_valid,
   input  logic               dn_ready,
   output logic [XLEN-1:0]    dn_in,
   output logic [1:0]         dn_sel,
   output logic [SHAMT_W-1:0] dn_B,
   output logic [4:0]         dn_rd,
   output logic               dn_illegal
);

   // One buffered, already-decoded entry.
   typedef struct packed {
      logic [XLEN-1:0]    data;
      logic [1:0]         sel;
      logic [SHAMT_W-1:0] amt;
      logic [4:0]         rd;
      logic               illegal;
   } entry_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SRX     = 3'b101;

   state_t state_q;
   entry_t main_q;
   entry_t skid_q;
   logic   up_ready_q;
   logic   dn_valid_q;

   // ------------------------------------------------------------------
   // Combinational decode of the upstream word
   // ------------------------------------------------------------------
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       is_imm;
   logic       is_reg;
   logic       is_left;
   logic       is_right;
   logic       f7_ok;
   logic       shift_ok;
   entry_t     dec_d;

   assign opcode   = up_instr[6:0];
   assign funct3   = up_instr[14:12];
   assign is_imm   = (opcode == OPC_OP_IMM);
   assign is_reg   = (opcode == OPC_OP);
   assign is_left  = (funct3 == F3_SLL);
   assign is_right = (funct3 == F3_SRX);

`ifdef SHIFT_ILLEGAL_CHK_EN
   // Left shifts only have the all-zero funct7; right shifts may also carry
   // the arithmetic marker 0100000 and nothing else.
   assign f7_ok = is_left ? (up_instr[31:25] == 7'b0000000)
                          : ((up_instr[31:25] == 7'b0000000) ||
                             (up_instr[31:25] == 7'b0100000));
`else
   assign f7_ok = 1'b1;
`endif

   assign shift_ok = (is_imm || is_reg) && (is_left || is_right) && f7_ok;

   always_comb begin
      dec_d         = '0;
      dec_d.data    = up_rs1;
      dec_d.rd      = up_instr[11:7];
      dec_d.illegal = !shift_ok;
      if (shift_ok) begin
         // instr[30] selects arithmetic only for right shifts; a left shift is
         // always logical regardless of that bit.
         dec_d.sel = is_left ? 2'b10 : {1'b0, up_instr[30]};
         dec_d.amt = is_imm ? up_instr[20 +: SHAMT_W] : up_rs2[SHAMT_W-1:0];
      end
   end

   // Fields not consumed by decode in every build configuration.
   logic unused_bits;
   assign unused_bits = ^{up_instr[31:25], up_instr[19:15], up_rs2[XLEN-1:SHAMT_W]};

   // ------------------------------------------------------------------
   // Handshakes: both qualifiers come from flops only.
   // ------------------------------------------------------------------
   logic up_xfer;
   logic dn_xfer;

   assign up_xfer = up_valid & up_ready_q;
   assign dn_xfer = dn_valid_q & dn_ready;

   // ------------------------------------------------------------------
   // Skid-buffer FSM with registered handshake outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         up_ready_q <= 1'b1;
         dn_valid_q <= 1'b0;
      end else if (flush) begin
         // Flush wins over any same-cycle transfer; the data fields keep
         // their last value since they are don't-care while dn_valid is low.
         state_q    <= ST_EMPTY;
         up_ready_q <= 1'b1;
         dn_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (up_xfer) begin
                  main_q     <= dec_d;
                  state_q    <= ST_ONE;
                  dn_valid_q <= 1'b1;
               end
            end
            ST_ONE: begin
               if (up_xfer && dn_xfer) begin
                  // Streaming: main hands off and reloads in the same edge.
                  main_q <= dec_d;
               end else if (up_xfer) begin
                  // Downstream stalled; park the new entry in skid and
                  // stop accepting from the next cycle on.
                  skid_q     <= dec_d;
                  state_q    <= ST_FULL;
                  up_ready_q <= 1'b0;
               end else if (dn_xfer) begin
                  state_q    <= ST_EMPTY;
                  dn_valid_q <= 1'b0;
               end
            end
            ST_FULL: begin
               // up_ready is low here, so only the drain side can move.
               if (dn_xfer) begin
                  main_q     <= skid_q;
                  state_q    <= ST_ONE;
                  up_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q    <= ST_EMPTY;
               up_ready_q <= 1'b1;
               dn_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign up_ready   = up_ready_q;
   assign dn_valid   = dn_valid_q;
   assign dn_in      = main_q.data;
   assign dn_sel     = main_q.sel;
   assign dn_B       = main_q.amt;
   assign dn_rd      = main_q.rd;
   assign dn_illegal = main_q.illegal;

endmodule

// File: tb/tb_shift_issue_stage.sv
// tb_shift_issue_stage - directed bench for shift_issue_stage.
// A queue-based model of the stage is compared against the DUT every cycle,
// plus literal expectations at the key points of each directed scenario.

module tb_shift_issue_stage;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        up_valid;
   logic        up_ready;
   logic [31:0] up_instr;
   logic [31:0] up_rs1;
   logic [31:0] up_rs2;
   logic        dn_valid;
   logic        dn_ready;
   logic [31:0] dn_in;
   logic [1:0]  dn_sel;
   logic [4:0]  dn_B;
   logic [4:0]  dn_rd;
   logic        dn_illegal;

   int checks = 0;
   int errors = 0;

   shift_issue_stage #(.XLEN(32), .SHAMT_W(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .up_valid   (up_valid),
      .up_ready   (up_ready),
      .up_instr   (up_instr),
      .up_rs1     (up_rs1),
      .up_rs2     (up_rs2),
      .dn_valid   (dn_valid),
      .dn_ready   (dn_ready),
      .dn_in      (dn_in),
      .dn_sel     (dn_sel),
      .dn_B       (dn_B),
      .dn_rd      (dn_rd),
      .dn_illegal (dn_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------------
   // Model: a FIFO of expected entries, at most two deep.
   // ------------------------------------------------------------------
   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  sel;
      logic [4:0]  amt;
      logic [4:0]  rd;
      logic        ill;
   } ent_t;

   ent_t mq[$];

   function automatic ent_t model_decode(input logic [31:0] ins, input logic [31:0] rs1,
                                         input logic [31:0] rs2);
      ent_t  e;
      string mn;
      logic [6:0] f7;
      e.data = rs1;
      e.rd   = ins[11:7];
      e.sel  = 2'b00;
      e.amt  = 5'd0;
      e.ill  = 1'b1;
      f7     = ins[31:25];
      mn     = "";
      if (ins[6:0] == 7'h13 && ins[14:12] == 3'd1) mn = "SLLI";
      if (ins[6:0] == 7'h13 && ins[14:12] == 3'd5) mn = ins[30] ? "SRAI" : "SRLI";
      if (ins[6:0] == 7'h33 && ins[14:12] == 3'd1) mn = "SLL";
      if (ins[6:0] == 7'h33 && ins[14:12] == 3'd5) mn = ins[30] ? "SRA" : "SRL";
`ifdef SHIFT_ILLEGAL_CHK_EN
      if ((mn == "SRA" || mn == "SRAI") && f7 != 7'h20) mn = "";
      if ((mn == "SLL" || mn == "SLLI" || mn == "SRL" || mn == "SRLI") && f7 != 7'h00) mn = "";
`endif
      if (mn != "") begin
         e.ill = 1'b0;
         if (mn == "SLL" || mn == "SLLI") e.sel = 2'b10;
         else if (mn == "SRA" || mn == "SRAI") e.sel = 2'b01;
         else e.sel = 2'b00;
         if (mn == "SLLI" || mn == "SRLI" || mn == "SRAI") e.amt = ins[24:20];
         else e.amt = rs2 % 32;
      end
      return e;
   endfunction

   bit m_up;
   bit m_dn;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
      end else if (flush) begin
         mq.delete();
      end else begin
         m_up = up_valid && (mq.size() < 2);
         m_dn = dn_ready && (mq.size() > 0);
         if (m_dn) void'(mq.pop_front());
         if (m_up) mq.push_back(model_decode(up_instr, up_rs1, up_rs2));
      end
   end

   // Per-cycle compare, away from the active edge.
   logic        exp_v;
   logic        exp_r;
   ent_t        exp_e;
   ent_t        act_e;

   always @(negedge clk) begin
      exp_v = (mq.size() > 0);
      exp_r = (mq.size() < 2);
      exp_e = exp_v ? mq[0] : '0;
      act_e = {dn_in, dn_sel, dn_B, dn_rd, dn_illegal};
      checks++;
      if (dn_valid !== exp_v || up_ready !== exp_r ||
          (exp_v && act_e !== exp_e)) begin
         errors++;
         $display("FAIL cycle_cmp t=%0t: got valid=%b ready=%b entry=%h, expected valid=%b ready=%b entry=%h",
                  $time, dn_valid, up_ready, act_e, exp_v, exp_r, exp_e);
      end
   end

   // ------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
      up_valid = 1'b1;
      up_instr = ins;
      up_rs1   = r1;
      up_rs2   = r2;
   endtask

   logic [31:0] burst_ins [8];
   logic        acc;
   int          waited;

   initial begin
      burst_ins[0] = 32'h01F15393;   // SRLI x7,x2,31
      burst_ins[1] = 32'h4041D413;   // SRAI x8,x3,4
      burst_ins[2] = 32'h002094B3;   // SLL  x9,x1,x2
      burst_ins[3] = 32'h0020D533;   // SRL  x10,x1,x2
      burst_ins[4] = 32'h6041D413;   // SRAI with funct7 0110000
      burst_ins[5] = 32'h00002083;   // LW (not a shift)
      burst_ins[6] = 32'h406251B3;   // SRA  x3,x4,x6
      burst_ins[7] = 32'h00309293;   // SLLI x5,x1,3

      rst = 1'b1; flush = 1'b0; up_valid = 1'b0; dn_ready = 1'b0;
      up_instr = '0; up_rs1 = '0; up_rs2 = '0;
      #1;
      chk("reset_dn_valid", {31'd0, dn_valid}, 32'd0);
      chk("reset_up_ready", {31'd0, up_ready}, 32'd1);
      chk("reset_fields", {dn_in ^ {dn_sel, dn_B, dn_rd, dn_illegal, 19'd0}}, 32'd0);
      step; step;
      rst = 1'b0;
      step;

      // SLLI x5,x1,3
      drive(32'h00309293, 32'h000000F0, 32'h0); dn_ready = 1'b1;
      step; up_valid = 1'b0; #1;
      chk("slli_valid", {31'd0, dn_valid}, 32'd1);
      chk("slli_sel",   {30'd0, dn_sel}, 32'd2);
      chk("slli_B",     {27'd0, dn_B}, 32'd3);
      chk("slli_in",    dn_in, 32'h000000F0);
      chk("slli_rd",    {27'd0, dn_rd}, 32'd5);
      chk("slli_ill",   {31'd0, dn_illegal}, 32'd0);

      // SRA x3,x4,x6 with rs2 = 0x25 -> amount 5
      step;
      drive(32'h406251B3, 32'h80000000, 32'h00000025);
      step; up_valid = 1'b0; #1;
      chk("sra_sel", {30'd0, dn_sel}, 32'd1);
      chk("sra_B",   {27'd0, dn_B}, 32'd5);
      chk("sra_rd",  {27'd0, dn_rd}, 32'd3);
      chk("sra_ill", {31'd0, dn_illegal}, 32'd0);
      chk("sra_in",  dn_in, 32'h80000000);

      // A, B, C back to back with downstream stalled
      step;
      dn_ready = 1'b0;
      drive(32'h002094B3, 32'h0000000A, 32'h1);    // A
      step;
      drive(32'h0020D533, 32'h0000000B, 32'h2);    // B
      step;
      drive(32'h4041D413, 32'h0000000C, 32'h3);    // C, must be held
      #1;
      chk("abc_full_ready", {31'd0, up_ready}, 32'd0);
      chk("abc_main_A", dn_in, 32'h0000000A);
      step; step;
      dn_ready = 1'b1;
      step; #1;
      chk("abc_B_next", dn_in, 32'h0000000B);
      chk("abc_ready_back", {31'd0, up_ready}, 32'd1);
      step; up_valid = 1'b0; #1;
      chk("abc_C_next", dn_in, 32'h0000000C);
      step; #1;
      chk("abc_drained", {31'd0, dn_valid}, 32'd0);

      // Flush while FULL with an upstream offer
      step;
      dn_ready = 1'b0;
      drive(32'h00309293, 32'h0000000D, 32'h0);
      step;
      drive(32'h00309293, 32'h0000000E, 32'h0);
      step;
      drive(32'h00309293, 32'h0000000F, 32'h0);
      flush = 1'b1;
      step;
      flush = 1'b0; up_valid = 1'b0; #1;
      chk("flush_full_valid", {31'd0, dn_valid}, 32'd0);
      chk("flush_full_ready", {31'd0, up_ready}, 32'd1);
      dn_ready = 1'b1;
      step; step; step;

      // Flush in ONE with a simultaneous upstream transfer
      dn_ready = 1'b0;
      drive(32'h0020D533, 32'h00000010, 32'h4);
      step;
      drive(32'h0020D533, 32'h00000011, 32'h4);
      flush = 1'b1;
      step;
      flush = 1'b0; up_valid = 1'b0; #1;
      chk("flush_one_valid", {31'd0, dn_valid}, 32'd0);
      dn_ready = 1'b1;
      step; step;

      // ADD x3,x1,x2 is forwarded but illegal
      drive(32'h002081B3, 32'h00001234, 32'h00000007);
      step; up_valid = 1'b0; #1;
      chk("add_ill", {31'd0, dn_illegal}, 32'd1);
      chk("add_sel", {30'd0, dn_sel}, 32'd0);
      chk("add_B",   {27'd0, dn_B}, 32'd0);
      chk("add_rd",  {27'd0, dn_rd}, 32'd3);
      chk("add_in",  dn_in, 32'h00001234);

      // SLLI with funct7 = 0000001
      step;
      drive(32'h02309293, 32'h00000055, 32'h0);
      step; up_valid = 1'b0; #1;
`ifdef SHIFT_ILLEGAL_CHK_EN
      chk("slli_f7_ill", {31'd0, dn_illegal}, 32'd1);
      chk("slli_f7_B",   {27'd0, dn_B}, 32'd0);
`else
      chk("slli_f7_ill", {31'd0, dn_illegal}, 32'd0);
      chk("slli_f7_sel", {30'd0, dn_sel}, 32'd2);
      chk("slli_f7_B",   {27'd0, dn_B}, 32'd3);
`endif
      step;

      // Burst with varying downstream readiness; the model tracks ordering.
      for (int i = 0; i < 24; i++) begin
         drive(burst_ins[i % 8], 32'h100 + i, 32'h20 + i);
         waited = 0;
         do begin
            acc      = up_ready;
            dn_ready = ($urandom_range(0, 2) != 0);
            step;
            waited++;
         end while (!acc && waited < 50);
         if (!acc) begin
            chk("burst_accept_timeout", 32'd0, 32'd1);
            break;
         end
      end
      up_valid = 1'b0; dn_ready = 1'b1;
      step; step; step;

      // Async reset between edges while FULL
      dn_ready = 1'b0;
      drive(32'h4041D413, 32'h00000077, 32'h0);
      step; step;
      rst = 1'b1; up_valid = 1'b0;
      #1;
      chk("arst_valid", {31'd0, dn_valid}, 32'd0);
      chk("arst_ready", {31'd0, up_ready}, 32'd1);
      chk("arst_in",    dn_in, 32'd0);
      chk("arst_sel",   {30'd0, dn_sel}, 32'd0);
      chk("arst_B",     {27'd0, dn_B}, 32'd0);
      chk("arst_rd",    {27'd0, dn_rd}, 32'd0);
      chk("arst_ill",   {31'd0, dn_illegal}, 32'd0);
      #1;
      rst = 1'b0;
      step;
      drive(32'h00309293, 32'h00000099, 32'h0); dn_ready = 1'b1;
      step; up_valid = 1'b0; #1;
      chk("post_rst_valid", {31'd0, dn_valid}, 32'd1);
      chk("post_rst_in",    dn_in, 32'h00000099);
      chk("post_rst_B",     {27'd0, dn_B}, 32'd3);
      step; step;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
